uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single board UART transmit port (txdata/txclk/txready) between up to NREQ on-chip requesters. It sits inside top between the producer logic and the UART pins. It grants one requester per byte, presents the byte with one cycle of setup, strobes txclk, and waits for the transmitter's ready handshake before serving the next byte.

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit port between NREQ requesters.
// One byte per grant: setup cycle, one-cycle txclk strobe, then the txready handshake.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                    hz100,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       reqdata,
    output logic [NREQ-1:0]         ack,
    output logic [7:0]              txdata,
    output logic                    txclk,
    input  logic                    txready,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] last_grant,
    output logic [15:0]             sent_count
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    // WAIT_BUSY is left as the counter would step to TIMEOUT-1, so IDLE is
    // re-entered TIMEOUT cycles after the strobe.
    localparam int WAIT_LAST = (TIMEOUT > 1) ? (TIMEOUT - 2) : 0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT_BUSY,
        WAIT_READY
    } state_t;

    state_t          state, state_n;
    logic [7:0]      txdata_n;
    logic            txclk_n;
    logic [NREQ-1:0] ack_n;
    logic            busy_n;
    logic [GW-1:0]   last_grant_n;
    logic [15:0]     sent_count_n;
    logic [CW-1:0]   tmo_cnt, tmo_cnt_n;

    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [GW-1:0]   cand;
    logic [7:0]      win_data;

    // Priority begins just after the last winner and wraps around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == GW'(i)) begin
                win_data = reqdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_n      = state;
        txdata_n     = txdata;
        txclk_n      = 1'b0;
        ack_n        = '0;
        last_grant_n = last_grant;
        sent_count_n = sent_count;
        tmo_cnt_n    = tmo_cnt;
        case (state)
            IDLE: begin
                if (win_found && txready) begin
                    state_n         = SETUP;
                    txdata_n        = win_data;
                    ack_n[win_idx]  = 1'b1;
                    last_grant_n    = win_idx;
                end
            end
            SETUP: begin
                state_n      = STROBE;
                txclk_n      = 1'b1;
                sent_count_n = sent_count + 16'd1;
            end
            STROBE: begin
                state_n   = WAIT_BUSY;
                tmo_cnt_n = '0;
            end
            WAIT_BUSY: begin
                if (!txready) begin
                    state_n = WAIT_READY;
                end else if (tmo_cnt == CW'(WAIT_LAST)) begin
                    state_n = IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + CW'(1);
                end
            end
            WAIT_READY: begin
                if (txready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // Every output is a register loaded from the next-state logic above.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            txdata     <= 8'h00;
            txclk      <= 1'b0;
            ack        <= '0;
            busy       <= 1'b0;
            last_grant <= GW'(NREQ - 1);
            sent_count <= 16'h0000;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_n;
            txdata     <= txdata_n;
            txclk      <= txclk_n;
            ack        <= ack_n;
            busy       <= busy_n;
            last_grant <= last_grant_n;
            sent_count <= sent_count_n;
            tmo_cnt    <= tmo_cnt_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a producer/transmitter model drives the DUT,
// predicted grants are queued and a separate monitor pops them on every ack.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic              hz100 = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] reqdata = '0;
    logic [NREQ-1:0]   ack;
    logic [7:0]        txdata;
    logic              txclk;
    logic              txready;
    logic              busy;
    logic [1:0]        last_grant;
    logic [15:0]       sent_count;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } expect_t;

    expect_t     expQ[$];
    expect_t     e;
    int          nChecks = 0;
    int          nFails = 0;
    int          lastModel = NREQ - 1;
    logic [15:0] expCount = 16'h0000;
    bit          expectStrobe = 1'b0;
    logic [7:0]  strobeData = 8'h00;
    int          dropDelay = 1;
    int          busyLen = 1;
    bit          holdLow = 1'b0;
    int          dropCnt = 0;
    int          lowCnt = 0;
    int          fairOrder [9];

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .hz100(hz100), .reset(reset), .req(req), .reqdata(reqdata),
        .ack(ack), .txdata(txdata), .txclk(txclk), .txready(txready),
        .busy(busy), .last_grant(last_grant), .sent_count(sent_count)
    );

    always #5 hz100 = ~hz100;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Round-robin rule: scan from the requester after the last winner, wrapping.
    function automatic int rrNext(input logic [NREQ-1:0] mask, input int last);
        int order[$];
        int result;
        result = -1;
        for (int k = 1; k <= NREQ; k++) order.push_back((last + k) % NREQ);
        foreach (order[i]) begin
            if (result < 0 && mask[order[i]]) result = order[i];
        end
        return result;
    endfunction

    task automatic pushExpect();
        expect_t t;
        int w;
        if (req != '0) begin
            w = rrNext(req, lastModel);
            t.idx = w;
            t.data = reqdata[8*w +: 8];
            expQ.push_back(t);
            lastModel = w;
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] mask, input logic [8*NREQ-1:0] bytes);
        reqdata = bytes;
        req = mask;
        pushExpect();
    endtask

    task automatic waitAck(output int idx, output int gap);
        idx = -1;
        gap = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge hz100);
            gap++;
            if (ack != '0) begin
                for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
                break;
            end
        end
        if (idx < 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL ack_wait: got no ack within 100 cycles, expected one");
        end
    endtask

    task automatic waitIdle(input string name);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 100) begin
            @(negedge hz100);
            c++;
        end
        if (busy !== 1'b0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s: got busy=%b after 100 cycles, expected 0", name, busy);
        end
        @(negedge hz100);
    endtask

    task automatic doReset();
        @(negedge hz100);
        reset = 1'b0;
        req = '0;
        repeat (2) @(negedge hz100);
        expQ.delete();
        lastModel = NREQ - 1;
        checkOutput("reset_pulse_count", 32'(sent_count), 32'd0);
        checkOutput("reset_pulse_grant", 32'(last_grant), 32'(NREQ - 1));
        reset = 1'b1;
    endtask

    task automatic runRandom(input int nBytes);
        int got, guard, idx, j;
        logic [NREQ-1:0] mask;
        got = 0;
        guard = 0;
        while ((got < nBytes || req != '0) && guard < 20000) begin
            @(negedge hz100);
            guard++;
            if (ack != '0) begin
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
                got++;
                if (got >= nBytes) begin
                    req[idx] = 1'b0;
                end else begin
                    if ($urandom_range(1, 0) == 1) reqdata[8*idx +: 8] = 8'($urandom);
                    else req[idx] = 1'b0;
                    j = int'($urandom_range(NREQ - 1, 0));
                    if (!req[j]) begin
                        reqdata[8*j +: 8] = 8'($urandom);
                        req[j] = 1'b1;
                    end
                    dropDelay = int'($urandom_range(3, 0));
                    busyLen = int'($urandom_range(6, 1));
                end
                pushExpect();
            end else if (got < nBytes && req == '0 && $urandom_range(3, 0) == 0) begin
                mask = NREQ'($urandom_range(15, 1));
                for (int i = 0; i < NREQ; i++) if (mask[i]) reqdata[8*i +: 8] = 8'($urandom);
                req = mask;
                pushExpect();
            end
        end
        checkOutput("rand_pending", 32'(req), 32'd0);
    endtask

    // Transmitter model: after a strobe, optionally drops txready for busyLen cycles.
    initial begin
        txready = 1'b1;
        forever begin
            @(negedge hz100);
            if (holdLow) begin
                txready = 1'b0;
                dropCnt = 0;
                lowCnt = 0;
            end else begin
                if (lowCnt > 0) begin
                    lowCnt--;
                    if (lowCnt == 0) txready = 1'b1;
                end else if (dropCnt > 0) begin
                    dropCnt--;
                    if (dropCnt == 0) begin
                        txready = 1'b0;
                        lowCnt = busyLen;
                    end
                end else begin
                    txready = 1'b1;
                end
                if (txclk === 1'b1 && dropDelay > 0) dropCnt = dropDelay;
            end
        end
    end

    // Monitor: every ack must match the oldest predicted grant; the strobe follows one cycle later.
    initial begin
        forever begin
            @(negedge hz100);
            if (reset !== 1'b1) begin
                expectStrobe = 1'b0;
                expCount = 16'h0000;
            end else begin
                checkOutput("txclk", 32'(txclk), 32'(expectStrobe));
                if (expectStrobe) begin
                    checkOutput("strobe_txdata", 32'(txdata), 32'(strobeData));
                    expCount = expCount + 16'd1;
                    checkOutput("sent_count", 32'(sent_count), 32'(expCount));
                    expectStrobe = 1'b0;
                end
                if (ack != '0) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL unexpected_ack: got ack=%b, expected no grant", ack);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("ack_onehot", 32'(ack), 32'd1 << e.idx);
                        checkOutput("grant_txdata", 32'(txdata), 32'(e.data));
                        checkOutput("last_grant", 32'(last_grant), 32'(e.idx));
                        checkOutput("busy_in_setup", 32'(busy), 32'd1);
                        strobeData = e.data;
                        expectStrobe = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int idx, gap, n;
        fairOrder = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

        $display("[TB] reset state");
        for (int c = 0; c < 4; c++) begin
            @(negedge hz100);
            req = NREQ'($urandom);
            reqdata = $urandom;
            checkOutput("rst_txclk", 32'(txclk), 32'd0);
            checkOutput("rst_ack", 32'(ack), 32'd0);
            checkOutput("rst_txdata", 32'(txdata), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_last_grant", 32'(last_grant), 32'd3);
            checkOutput("rst_sent_count", 32'(sent_count), 32'd0);
        end
        @(negedge hz100);
        req = '0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge hz100);
            checkOutput("idle_ack", 32'(ack), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("idle_txdata", 32'(txdata), 32'd0);
            checkOutput("idle_last_grant", 32'(last_grant), 32'd3);
        end

        $display("[TB] single transfer");
        dropDelay = 1;
        busyLen = 10;
        applyStimulus(4'b0001, 32'h0000_0041);
        waitAck(idx, gap);
        checkOutput("single_latency", 32'(gap), 32'd1);
        checkOutput("single_ack", 32'(ack), 32'h1);
        checkOutput("single_txdata", 32'(txdata), 32'h41);
        req = '0;
        @(negedge hz100);
        checkOutput("single_txclk", 32'(txclk), 32'd1);
        checkOutput("single_count", 32'(sent_count), 32'd1);
        repeat (11) @(negedge hz100);
        checkOutput("single_busy_before", 32'(busy), 32'd1);
        @(negedge hz100);
        checkOutput("single_busy_after", 32'(busy), 32'd0);
        checkOutput("single_txdata_hold", 32'(txdata), 32'h41);

        $display("[TB] fairness");
        doReset();
        dropDelay = 1;
        busyLen = 1;
        applyStimulus(4'b1111, 32'hA3A2_A1A0);
        for (int j = 0; j < 9; j++) begin
            waitAck(idx, gap);
            checkOutput("fair_order", 32'(idx), 32'(fairOrder[j]));
            checkOutput("fair_data", 32'(txdata), 32'(8'hA0 + fairOrder[j]));
            if (j > 0) checkOutput("byte_period", 32'(gap), 32'd5);
            if (j == 5) req[1] = 1'b0;
            if (j == 8) req = '0;
            else pushExpect();
        end
        waitIdle("fair_idle");

        $display("[TB] timeout");
        dropDelay = 0;
        applyStimulus(4'b0100, 32'h005C_0000);
        waitAck(idx, gap);
        req = '0;
        @(negedge hz100);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge hz100);
            n++;
            if (busy == 1'b0) break;
        end
        checkOutput("timeout_cycles", 32'(n), 32'(TIMEOUT));
        checkOutput("timeout_count", 32'(sent_count), 32'(expCount));
        applyStimulus(4'b0001, 32'h0000_0011);
        waitAck(idx, gap);
        req = '0;
        checkOutput("timeout_next", 32'(idx), 32'd0);
        waitIdle("timeout_idle");

        $display("[TB] blocking");
        dropDelay = 1;
        busyLen = 2;
        @(posedge hz100);
        #2 holdLow = 1'b1;
        repeat (2) @(negedge hz100);
        applyStimulus(4'b0100, 32'h00C7_0000);
        repeat (5) begin
            @(negedge hz100);
            checkOutput("block_noack", 32'(ack), 32'd0);
            checkOutput("block_busy", 32'(busy), 32'd0);
        end
        @(posedge hz100);
        #2 holdLow = 1'b0;
        @(negedge hz100);
        checkOutput("block_still_idle", 32'(ack), 32'd0);
        @(negedge hz100);
        checkOutput("block_grant", 32'(ack), 32'b0100);
        req = '0;
        waitIdle("block_idle");

        $display("[TB] randomized traffic");
        runRandom(250);
        waitIdle("rand_idle");
        checkOutput("rand_queue_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] sent_count wrap");
        dropDelay = 1;
        busyLen = 1;
        @(posedge hz100);
        #2;
        force dut.sent_count = 16'hFFFF;
        expCount = 16'hFFFF;
        #1 release dut.sent_count;
        @(negedge hz100);
        checkOutput("wrap_preload", 32'(sent_count), 32'hFFFF);
        applyStimulus(4'b0010, 32'h0000_9900);
        waitAck(idx, gap);
        req = '0;
        @(negedge hz100);
        checkOutput("wrap_zero", 32'(sent_count), 32'h0000);
        waitIdle("wrap_idle");

        $display("[TB] reset during strobe");
        applyStimulus(4'b0010, 32'h0000_3E00);
        waitAck(idx, gap);
        req = '0;
        @(posedge hz100);
        #2;
        checkOutput("mid_strobe", 32'(txclk), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid_txclk_async", 32'(txclk), 32'd0);
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_ack", 32'(ack), 32'd0);
        checkOutput("mid_count", 32'(sent_count), 32'd0);
        checkOutput("mid_last_grant", 32'(last_grant), 32'd3);
        checkOutput("mid_txdata", 32'(txdata), 32'd0);
        expQ.delete();
        lastModel = NREQ - 1;
        repeat (2) @(negedge hz100);
        reset = 1'b1;
        repeat (4) begin
            @(negedge hz100);
            checkOutput("mid_no_reack", 32'(ack), 32'd0);
            checkOutput("mid_idle_busy", 32'(busy), 32'd0);
        end
        applyStimulus(4'b0001, 32'h0000_0077);
        waitAck(idx, gap);
        req = '0;
        checkOutput("mid_recover", 32'(idx), 32'd0);
        waitIdle("mid_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
